// File: rtl/cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cache_pkg                                                    |
// | Purpose  : Shared types, default geometry and helpers for data_cache.   |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package cache_pkg;

   localparam int CACHE_DATA_WIDTH = 32;
   localparam int CACHE_ADDR_WIDTH = 32;
   localparam int CACHE_SETS       = 256;
   localparam int IDX_W            = $clog2(CACHE_SETS);
   localparam int TAG_W            = CACHE_ADDR_WIDTH - 2 - IDX_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } cache_state_t;

   // Saturating increment: an event counter parks at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cache_line_array                                             |
// | Purpose  : Valid/tag/data storage for a direct-mapped one-word-line     |
// |            cache. Asynchronous read, synchronous write and clear.       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module cache_line_array #(
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 256,
   parameter int IDX_W      = 8,
   parameter int TAG_W      = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic [SETS-1:0]       r_valid;
   logic [TAG_W-1:0]      r_tag  [SETS];
   logic [DATA_WIDTH-1:0] r_data [SETS];

   assign rd_valid = r_valid[rd_idx];
   assign rd_tag   = r_tag[rd_idx];
   assign rd_data  = r_data[rd_idx];

   // Valid bits: cleared together on reset, set by any line write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else if (wr_en) begin
         r_valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data payload; contents are meaningless while the valid bit is clear.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_tag[wr_idx]  <= wr_tag;
         r_data[wr_idx] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : data_cache                                                   |
// | Purpose  : Direct-mapped, write-through, no-write-allocate data cache   |
// |            with a req/ack port to the backing RAM and hit/miss counters.|
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module data_cache
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
   parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
   parameter int SETS       = CACHE_SETS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt
);

   localparam int c_IDX_W = $clog2(SETS);
   localparam int c_TAG_W = ADDR_WIDTH - 2 - c_IDX_W;

   cache_state_t          r_state;
   logic                  r_st_done;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [31:0]           r_hit_cnt;
   logic [31:0]           r_miss_cnt;

   logic [c_IDX_W-1:0]    w_idx;
   logic [c_TAG_W-1:0]    w_tag;
   logic [ADDR_WIDTH-1:0] w_aligned;
   logic                  w_line_valid;
   logic [c_TAG_W-1:0]    w_line_tag;
   logic [DATA_WIDTH-1:0] w_line_data;
   logic                  w_hit;
   logic                  w_idle;
   logic                  w_load_hit;
   logic                  w_load_miss;
   logic                  w_store_new;
   logic                  w_fill;
   logic                  w_wr_en;
   logic [c_IDX_W-1:0]    w_wr_idx;
   logic [c_TAG_W-1:0]    w_wr_tag;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic                  w_stall;
   logic                  w_unused;

   assign w_idx     = cpu_addr[c_IDX_W+1:2];
   assign w_tag     = cpu_addr[ADDR_WIDTH-1:c_IDX_W+2];
   assign w_aligned = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
   assign w_unused  = &{1'b0, cpu_addr[1:0]};

   assign w_hit       = w_line_valid && (w_line_tag == w_tag);
   assign w_idle      = (r_state == IDLE);
   assign w_load_hit  = w_idle && cpu_req && !cpu_we && w_hit;
   assign w_load_miss = w_idle && cpu_req && !cpu_we && !w_hit;
   // A store retried in the cycle after its ack is already complete.
   assign w_store_new = w_idle && cpu_req && cpu_we && !r_st_done;
   assign w_fill      = (r_state == RD_MISS) && mem_ack;

   // Line writes come from a fill (address held in mem_addr) or a store hit.
   assign w_wr_en   = !rst && (w_fill || (w_store_new && w_hit));
   assign w_wr_idx  = w_fill ? r_mem_addr[c_IDX_W+1:2] : w_idx;
   assign w_wr_tag  = w_fill ? r_mem_addr[ADDR_WIDTH-1:c_IDX_W+2] : w_tag;
   assign w_wr_data = w_fill ? mem_rdata : cpu_wdata;

   cache_line_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .SETS       (SETS),
      .IDX_W      (c_IDX_W),
      .TAG_W      (c_TAG_W)
   ) u_lines (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (w_idx),
      .rd_valid (w_line_valid),
      .rd_tag   (w_line_tag),
      .rd_data  (w_line_data),
      .wr_en    (w_wr_en),
      .wr_idx   (w_wr_idx),
      .wr_tag   (w_wr_tag),
      .wr_data  (w_wr_data)
   );

   // Pipeline stall: any new RAM access in IDLE, and every busy cycle.
   always_comb begin
      w_stall = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE:    w_stall = w_load_miss || w_store_new;
            default: w_stall = 1'b1;
         endcase
      end
   end

   assign cpu_stall = w_stall;
   assign cpu_rdata = rst ? '0 : w_line_data;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;

   // Control FSM with registered memory-side request outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_st_done   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_st_done <= 1'b0;
               if (w_load_miss) begin
                  r_state    <= RD_MISS;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= w_aligned;
               end else if (w_store_new) begin
                  r_state     <= WR_THRU;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= w_aligned;
                  r_mem_wdata <= cpu_wdata;
               end
            end
            RD_MISS: begin
               if (mem_ack) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            WR_THRU: begin
               if (mem_ack) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_st_done <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Load hit/miss event counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_load_hit) r_hit_cnt <= sat_inc(r_hit_cnt);
         if (w_load_miss) r_miss_cnt <= sat_inc(r_miss_cnt);
      end
   end

endmodule
`default_nettype wire
